// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM states
//   DEF_*       : default parameter values
//   idx_w()     : bits needed to hold an index in [0, n-1], minimum 1
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 8;
    localparam int DEF_STALL_MAX = 16;

    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational circular-priority picker: returns the first set bit of
// i_req found when scanning upward from i_start and wrapping around.
// Ports:
//   i_req   : request vector
//   i_start : index scanned first (must be < N_REQ)
//   o_found : at least one request is set
//   o_idx   : index of the winning request (0 when none)
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IW   = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_start,
    output logic             o_found,
    output logic [IW-1:0]    o_idx
);

    int w_j;

    // Scan from the farthest offset down to zero so the nearest hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j = (int'(i_start) + k) % N_REQ;
            if (i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the FIFO write port between N_REQ requesters.
// One requester is granted per burst; a burst ends on a last word, after
// MAX_BURST words, or after STALL_MAX consecutive cycles without valid data.
// A full FIFO only pauses the burst.
//
// state | meaning
// IDLE  | no grant; arbitrate among req_valid starting after r_prio
// BURST | requester r_gnt owns the write port
//
// Ports:
//   i_wr_clk       : block clock
//   i_rst          : synchronous active-high reset
//   i_req_valid    : per-requester word available
//   i_req_data     : requester i word at [i*DATA_W +: DATA_W]
//   i_req_last     : per-requester word ends its burst
//   o_req_ready    : transfer accepted (one-hot or zero)
//   o_fifo_wr_en   : FIFO write enable
//   o_fifo_wr_data : FIFO write data
//   i_fifo_full    : FIFO full flag
//   o_grant_id     : current or last granted requester
//   o_busy         : high while in BURST
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int STALL_MAX = DEF_STALL_MAX,
    localparam int IW       = idx_w(N_REQ)
) (
    input  logic                    i_wr_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_fifo_wr_en,
    output logic [DATA_W-1:0]       o_fifo_wr_data,
    input  logic                    i_fifo_full,
    output logic [IW-1:0]           o_grant_id,
    output logic                    o_busy
);

    arb_state_e  r_state;
    logic [IW-1:0] r_gnt;
    logic [IW-1:0] r_prio;
    logic [7:0]    r_beat_cnt;
    logic [7:0]    r_stall_cnt;

    logic [IW-1:0] w_start;
    logic          w_found;
    logic [IW-1:0] w_pick;
    logic          w_burst;
    logic          w_valid_g;
    logic          w_last_g;
    logic          w_xfer;

    // Search begins one past the last winner, wrapping at N_REQ.
    assign w_start = (r_prio == IW'(N_REQ - 1)) ? '0 : r_prio + IW'(1);

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req   (i_req_valid),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_burst   = (r_state == BURST);
    assign w_valid_g = i_req_valid[r_gnt];
    assign w_last_g  = i_req_last[r_gnt];
    assign w_xfer    = w_burst && w_valid_g && !i_fifo_full;

    always_ff @(posedge i_wr_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_prio      <= IW'(N_REQ - 1);
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt       <= w_pick;
                        r_beat_cnt  <= '0;
                        r_stall_cnt <= '0;
                        r_state     <= BURST;
                    end
                end
                BURST: begin
                    if (w_xfer) begin
                        r_beat_cnt  <= r_beat_cnt + 8'd1;
                        r_stall_cnt <= '0;
                        if (w_last_g || (r_beat_cnt == 8'(MAX_BURST - 1))) begin
                            r_prio  <= r_gnt;
                            r_state <= IDLE;
                        end
                    end else if (!w_valid_g) begin
                        // Only an absent requester counts toward revocation;
                        // a full FIFO leaves the stall count untouched.
                        r_stall_cnt <= r_stall_cnt + 8'd1;
                        if (r_stall_cnt == 8'(STALL_MAX - 1)) begin
                            r_prio  <= r_gnt;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (w_burst) begin
            o_req_ready[r_gnt] = !i_fifo_full;
        end
    end

    assign o_fifo_wr_en = w_xfer;

    // The data mux must be combinational: the word is written in the same
    // cycle the requester presents it.
    assign o_fifo_wr_data = w_burst ? i_req_data[int'(r_gnt)*DATA_W +: DATA_W] : '0;

    assign o_grant_id = r_gnt;
    assign o_busy     = w_burst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;
    localparam int SM = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_full;
    logic [1:0]    grant_id;
    logic          busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (MB),
        .STALL_MAX (SM)
    ) dut (
        .i_wr_clk       (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .i_req_data     (req_data),
        .i_req_last     (req_last),
        .o_req_ready    (req_ready),
        .o_fifo_wr_en   (fifo_wr_en),
        .o_fifo_wr_data (fifo_wr_data),
        .i_fifo_full    (fifo_full),
        .o_grant_id     (grant_id),
        .o_busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    // reference model: who owns the port, how long it has had it
    bit m_busy;
    int m_gnt, m_prio, m_beats, m_idle;

    // requester sources
    int seq[N];
    int wcnt[N];
    int blen[N];
    int off_cnt[N];

    // observations for directed scenario checks
    int  grants[$];
    int  lens[$];
    int  cur_len;
    bit  prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] word(input int i);
        return 8'((i << 6) | (seq[i] & 63));
    endfunction

    task automatic m_reset();
        m_busy  = 1'b0;
        m_gnt   = 0;
        m_prio  = N - 1;
        m_beats = 0;
        m_idle  = 0;
    endtask

    task automatic clear_obs();
        grants.delete();
        lens.delete();
        cur_len = 0;
    endtask

    task automatic step(input logic [N-1:0] vv, input logic ff, input logic rr);
        logic [N-1:0]  e_rdy;
        logic          e_en;
        logic [DW-1:0] e_dat;
        logic [N-1:0]  lst;
        bit            found;
        int            j, g;
        @(negedge clk);
        req_valid = vv;
        fifo_full = ff;
        rst       = rr;
        for (int i = 0; i < N; i++) begin
            lst[i] = (blen[i] != 0) && (wcnt[i] == blen[i] - 1);
            req_data[i*DW +: DW] = word(i);
        end
        req_last = lst;
        #1;
        if (m_busy) begin
            e_rdy = ff ? '0 : N'(1 << m_gnt);
            e_en  = vv[m_gnt] && !ff;
            e_dat = word(m_gnt);
        end else begin
            e_rdy = '0;
            e_en  = 1'b0;
            e_dat = '0;
        end
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_en));
        chk("fifo_wr_data", 32'(fifo_wr_data), 32'(e_dat));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_gnt));

        if (busy && !prev_busy) grants.push_back(int'(grant_id));
        if (fifo_wr_en) cur_len++;
        if (!busy && prev_busy) begin
            lens.push_back(cur_len);
            cur_len = 0;
        end
        prev_busy = busy;

        for (int i = 0; i < N; i++) begin
            if (vv[i] && req_ready[i]) begin
                seq[i]++;
                if (lst[i]) wcnt[i] = 0;
                else wcnt[i]++;
            end
        end

        if (rr) begin
            m_reset();
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                j = (m_prio + k) % N;
                if (!found && vv[j]) begin
                    found   = 1'b1;
                    m_gnt   = j;
                    m_busy  = 1'b1;
                    m_beats = 0;
                    m_idle  = 0;
                end
            end
        end else begin
            g = m_gnt;
            if (vv[g] && !ff) begin
                m_beats++;
                m_idle = 0;
                if (lst[g] || m_beats == MB) begin
                    m_prio = g;
                    m_busy = 1'b0;
                end
            end else if (!vv[g]) begin
                m_idle++;
                if (m_idle == SM) begin
                    m_prio = g;
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    int exp1[5] = '{0, 1, 2, 3, 0};
    int start;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        prev_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; wcnt[i] = 0; blen[i] = 0; off_cnt[i] = 0;
        end
        clear_obs();
        repeat (3) @(posedge clk);
        m_reset();

        // reset state, then all four requesters with 2-word packets
        for (int i = 0; i < N; i++) blen[i] = 2;
        clear_obs();
        repeat (16) step(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            chk("s1_grant_order", (i < grants.size()) ? grants[i] : -1, exp1[i]);
        for (int i = 0; i < 4; i++)
            chk("s1_burst_len", (i < lens.size()) ? lens[i] : -1, 2);
        repeat (20) step(4'b0000, 1'b0, 1'b0);

        // requester 2 alone, 20 words, no last
        for (int i = 0; i < N; i++) begin blen[i] = 0; wcnt[i] = 0; end
        clear_obs();
        start = seq[2];
        repeat (70) step({1'b0, (seq[2] - start) < 20, 2'b00}, 1'b0, 1'b0);
        chk("s2_words", seq[2] - start, 20);
        chk("s2_ngrants", grants.size(), 3);
        chk("s2_len0", (lens.size() > 0) ? lens[0] : -1, 8);
        chk("s2_len1", (lens.size() > 1) ? lens[1] : -1, 8);
        chk("s2_len2", (lens.size() > 2) ? lens[2] : -1, 4);
        for (int i = 0; i < grants.size(); i++) chk("s2_grant_id", grants[i], 2);

        // full for 5 cycles mid-burst
        clear_obs();
        start = seq[0];
        repeat (4) step(4'b0001, 1'b0, 1'b0);
        repeat (5) step(4'b0001, 1'b1, 1'b0);
        repeat (3) step(4'b0001, 1'b0, 1'b0);
        repeat (20) step(4'b0000, 1'b0, 1'b0);
        chk("s3_ngrants", grants.size(), 1);
        chk("s3_len", (lens.size() > 0) ? lens[0] : -1, 6);
        chk("s3_words", seq[0] - start, 6);

        // requester 1 stops after 3 words; grant moves on to requester 2
        step(4'b0000, 1'b0, 1'b1);
        clear_obs();
        step(4'b0010, 1'b0, 1'b0);
        start = seq[1];
        repeat (40) step({1'b0, 1'b1, (seq[1] - start) < 3, 1'b0}, 1'b0, 1'b0);
        chk("s4_first_grant", (grants.size() > 0) ? grants[0] : -1, 1);
        chk("s4_second_grant", (grants.size() > 1) ? grants[1] : -1, 2);
        chk("s4_len", (lens.size() > 0) ? lens[0] : -1, 3);
        repeat (20) step(4'b0000, 1'b0, 1'b0);

        // reset during the 4th word of a burst
        step(4'b0000, 1'b0, 1'b1);
        repeat (4) step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        clear_obs();
        prev_busy = 1'b0;
        repeat (3) step(4'b1111, 1'b0, 1'b0);
        chk("s5_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
        repeat (20) step(4'b0000, 1'b0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [N-1:0] vr;
            if (n % 200 == 0) begin
                for (int i = 0; i < N; i++) begin
                    blen[i] = $urandom_range(0, 10);
                    wcnt[i] = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (off_cnt[i] > 0) begin
                    off_cnt[i]--;
                    vr[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 39) == 0) off_cnt[i] = $urandom_range(5, 25);
                    vr[i] = ($urandom_range(0, 9) < 7);
                end
            end
            step(vr, ($urandom_range(0, 4) == 0), ($urandom_range(0, 499) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the async FIFO between N_REQ requesters in the write clock domain. Each requester presents words over a valid/ready handshake with an optional last marker. The arbiter grants one requester at a time for a bounded burst and drives fifo_wr_en/fifo_wr_data, with back-pressure from fifo_full. It sits directly in front of the FIFO write side. All logic runs on wr_clk.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, word width; equals the FIFO data width
- MAX_BURST, 8, maximum words per grant before forced re-arbitration (1..255)
- STALL_MAX, 16, consecutive idle cycles of the granted requester before the grant is revoked (1..255)

Ports:
- wr_clk  in  1  single clock for the block
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i has a word
- req_data  in  N_REQ*DATA_W  word of requester i at bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  word of requester i ends its burst
- req_ready  out  N_REQ  transfer accepted; one-hot or zero
- fifo_wr_en  out  1  to the FIFO write enable
- fifo_wr_data  out  DATA_W  to the FIFO write data
- fifo_full  in  1  from the FIFO full flag
- grant_id  out  clog2(N_REQ)  current or last granted requester
- busy  out  1  high in state BURST

## Operation
- States: IDLE and BURST.
- Registers:
  - state
  - gnt (grant index)
  - prio (index of the last granted requester)
  - beat_cnt (8 bit)
  - stall_cnt (8 bit)
- IDLE:
  - If any req_valid is high, select the first requester with valid high, searching circularly from prio+1.
  - Load gnt, clear beat_cnt and stall_cnt, go to BURST.
  - If no req_valid is high, remain in IDLE.
- BURST, with g = gnt:
  - req_ready[g] = !fifo_full. All other ready bits are 0.
  - fifo_wr_en = req_valid[g] && !fifo_full.
  - fifo_wr_data = req_data[g] in every cycle of BURST. It is 0 in IDLE.
  - A transfer occurs when req_valid[g] && req_ready[g].
- On a transfer:
  - beat_cnt increments and stall_cnt clears.
  - If req_last[g] is high or beat_cnt == MAX_BURST-1: set prio <= g and go to IDLE.
- No transfer because req_valid[g] is low:
  - stall_cnt increments.
  - When stall_cnt == STALL_MAX-1: set prio <= g and go to IDLE (grant revoked).
- No transfer because fifo_full is high:
  - stall_cnt holds.
  - A full FIFO never revokes a grant.
- The grant is never changed mid-burst by requests from other requesters.
- fifo_wr_en is never asserted while fifo_full is high, so no word is lost or duplicated.
- Reset values:
  - state = IDLE, prio = N_REQ-1 (requester 0 wins the first arbitration), gnt = 0, counters = 0.
  - All outputs are 0: req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy.
- Reset mid-burst aborts the burst at once. Words already accepted remain in the FIFO.

## Timing
- Arbitration latency: req_valid is sampled high at edge k, gnt is registered at edge k, and the first transfer can happen at edge k+1.
- Combinational paths: req_ready and fifo_wr_en depend combinationally on fifo_full and req_valid. There is no other combinational input-to-output path.
- Throughput: a burst of B words uses B+1 cycles (one IDLE bubble per grant).
- Full back-pressure: stall cycles add 1:1 to burst length.
- Simultaneous last and MAX_BURST reached: a single exit to IDLE.
- grant_id holds its value in IDLE.

## Structure
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST}
  - width helper function for clog2
  - default parameter constants
- Sub-module rr_pick:
  - Combinational circular-priority picker.
  - Inputs: req vector and start index.
  - Outputs: found flag and index.
  - Instantiated once.

## Test plan
- Reset, then req_valid=4'b1111 and each requester sends 2 words with last on word 2.
  - Grant order is 0,1,2,3,0.
  - The FIFO receives the words in that order.
  - There is one idle cycle between bursts.
- Requester 2 alone sends 20 words with no last and MAX_BURST=8.
  - Three grants to 2, of 8, 8 and 4 words.
  - busy drops for one cycle between grants.
  - 20 words arrive in order.
- fifo_full held high for 5 cycles mid-burst.
  - fifo_wr_en and req_ready stay 0 for those cycles.
  - The grant is kept with no revocation.
  - The word on the bus is written on the first cycle after full falls.
- Granted requester 1 drops valid after 3 words, with STALL_MAX=16.
  - Grant revoked after 16 idle cycles.
  - The next grant goes to requester 2 (if valid).
- rst asserted during the 4th word of a burst.
  - The next cycle shows all outputs 0 and state IDLE.
  - After release, requester 0 is granted first.
